// File: rtl/camera_pattern_source.sv
// Synthetic camera transmitter: emits VSYNC/HREF framed YUV422 bytes of a selectable
// test pattern on the pixel clock, standing in for the image sensor during bring-up.
module camera_pattern_source #(
    parameter int H_ACTIVE    = 320,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 240,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        cam_pclk,
    input  logic        nreset,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int LINE_BYTES = 2 * H_ACTIVE + H_BLANK;
    localparam int ACT_BYTES  = 2 * H_ACTIVE;
    localparam int BW         = $clog2(LINE_BYTES);
    localparam int MAX_VB     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int MAX_AF     = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int MAX_LINES  = (MAX_VB > MAX_AF) ? MAX_VB : MAX_AF;
    localparam int LW         = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_BACK,
        ST_ACTIVE,
        ST_FRONT
    } state_t;

    state_t          r_state;
    logic [BW-1:0]   r_byte_cnt;
    logic [LW-1:0]   r_line_cnt;
    logic [1:0]      r_pattern;
    logic [7:0]      r_flat_y;

    logic            w_line_end;
    logic            w_last_line;
    logic            w_state_done;
    logic [7:0]      w_x;
    logic            w_y_b4;
    logic [7:0]      w_y_val;
    logic            w_vsync_next;
    logic            w_href_next;
    logic [7:0]      w_data_next;
    logic            w_fs_next;

    assign w_line_end   = (r_byte_cnt == BW'(LINE_BYTES - 1));
    assign w_state_done = w_line_end && w_last_line;

    // NOTE: every always_comb output gets a default before the case so no path infers a latch.
    always_comb begin
        w_last_line = 1'b0;
        case (r_state)
            ST_VSYNC:  w_last_line = (r_line_cnt == LW'(VSYNC_LINES - 1));
            ST_BACK:   w_last_line = (r_line_cnt == LW'(V_BACK - 1));
            ST_ACTIVE: w_last_line = (r_line_cnt == LW'(V_ACTIVE - 1));
            ST_FRONT:  w_last_line = (r_line_cnt == LW'(V_FRONT - 1));
            default:   w_last_line = 1'b0;
        endcase
    end

    // Pixel column and bit 4 of the active line index; both truncate safely for small geometries.
    assign w_x    = 8'(r_byte_cnt >> 1);
    assign w_y_b4 = ((r_line_cnt & LW'(16)) != '0);

    always_comb begin
        w_y_val = 8'h00;
        case (r_pattern)
            2'b00: w_y_val = w_x;
            2'b01: w_y_val = w_x[5] ? 8'hFF : 8'h00;
            2'b10: w_y_val = (w_x[4] ^ w_y_b4) ? 8'hFF : 8'h00;
            2'b11: w_y_val = r_flat_y;
            default: w_y_val = 8'h00;
        endcase
    end

    assign w_vsync_next = (r_state == ST_IDLE) || (r_state == ST_VSYNC);
    assign w_href_next  = (r_state == ST_ACTIVE) && (r_byte_cnt < BW'(ACT_BYTES));
    assign w_data_next  = !w_href_next  ? 8'h00 :
                          r_byte_cnt[0] ? 8'h80 : w_y_val;
    assign w_fs_next    = (r_state == ST_BACK) && (r_line_cnt == '0) && (r_byte_cnt == '0);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge cam_pclk or negedge nreset) begin
        if (!nreset) begin
            r_state     <= ST_IDLE;
            r_byte_cnt  <= '0;
            r_line_cnt  <= '0;
            r_pattern   <= 2'b00;
            r_flat_y    <= 8'h00;
            cam_vsync   <= 1'b1;
            cam_href    <= 1'b0;
            cam_data    <= 8'h00;
            frame_start <= 1'b0;
            frame_count <= 16'h0000;
        end else begin
            cam_vsync   <= w_vsync_next;
            cam_href    <= w_href_next;
            cam_data    <= w_data_next;
            frame_start <= w_fs_next;

            // A frame completes exactly when the registered VSYNC goes back high.
            if (w_vsync_next && !cam_vsync) begin
                frame_count <= frame_count + 16'd1;
            end

            if (r_state == ST_IDLE) begin
                r_byte_cnt <= '0;
                r_line_cnt <= '0;
                if (enable) begin
                    r_state <= ST_VSYNC;
                end
            end else begin
                if (w_line_end) begin
                    r_byte_cnt <= '0;
                    r_line_cnt <= w_state_done ? '0 : r_line_cnt + LW'(1);
                end else begin
                    r_byte_cnt <= r_byte_cnt + BW'(1);
                end

                if (w_state_done) begin
                    case (r_state)
                        ST_VSYNC: begin
                            r_state   <= ST_BACK;
                            r_pattern <= pattern_sel;
                            r_flat_y  <= frame_count[7:0];
                        end
                        ST_BACK:   r_state <= ST_ACTIVE;
                        ST_ACTIVE: r_state <= ST_FRONT;
                        ST_FRONT:  r_state <= enable ? ST_VSYNC : ST_IDLE;
                        default:   r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_camera_pattern_source.sv
// Scoreboard bench for camera_pattern_source: stimulus pushes whole expected frames,
// a negedge monitor pops one byte per HREF-high cycle and checks frame geometry.
module tb_camera_pattern_source;

    localparam int HA        = 260;
    localparam int HB        = 4;
    localparam int VA        = 17;
    localparam int VS        = 1;
    localparam int VB        = 1;
    localparam int VF        = 1;
    localparam int LB        = 2 * HA + HB;
    localparam int FRAME_LOW = (VB + VA + VF) * LB;
    localparam int FRAME_ALL = (VS + VB + VA + VF) * LB;

    logic        clk = 1'b0;
    logic        nreset;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        frame_start;
    logic [15:0] frame_count;

    int          tests = 0;
    int          fails = 0;
    int          frames_done = 0;
    logic [7:0]  exp_q[$];

    camera_pattern_source #(
        .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
        .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .cam_pclk   (clk),
        .nreset     (nreset),
        .enable     (enable),
        .pattern_sel(pattern_sel),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .frame_start(frame_start),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Luma of pixel (x, y) straight from the pattern definitions.
    function automatic logic [7:0] model_y(input int pat, input int x, input int y, input int flat);
        case (pat)
            0:       return 8'(x % 256);
            1:       return (((x / 32) % 2) == 1) ? 8'hFF : 8'h00;
            2:       return (((x / 16) % 2) != ((y / 16) % 2)) ? 8'hFF : 8'h00;
            default: return 8'(flat % 256);
        endcase
    endfunction

    task automatic push_frame(input int pat, input int flat);
        for (int y = 0; y < VA; y++) begin
            for (int b = 0; b < 2 * HA; b++) begin
                exp_q.push_back(((b % 2) == 1) ? 8'h80 : model_y(pat, b / 2, y, flat));
            end
        end
    endtask

    // Monitor: byte scoreboard plus burst, gap, VSYNC and frame counter geometry.
    logic m_prev_vsync = 1'b1;
    logic m_prev_href  = 1'b0;
    int   m_run = 0, m_gap = 0, m_bursts = 0, m_fs = 0, m_low = 0, m_fc = 0;

    always @(negedge clk) begin
        if (!nreset) begin
            exp_q.delete();
            m_prev_vsync = 1'b1;
            m_prev_href  = 1'b0;
            m_run = 0; m_gap = 0; m_bursts = 0; m_fs = 0; m_low = 0; m_fc = 0;
        end else begin
            if (frame_start) begin
                check("frame_start_on_vsync_fall", {31'd0, m_prev_vsync && !cam_vsync}, 1);
                m_fs++;
            end
            if (m_prev_vsync && !cam_vsync) begin
                check("frame_start_at_fall", {31'd0, frame_start}, 1);
                check("frame_queued", exp_q.size(), VA * 2 * HA);
                m_low = 0;
                m_bursts = 0;
                m_fs = frame_start ? 1 : 0;
            end
            if (!cam_vsync) m_low++;

            if (cam_href) begin
                if (!m_prev_href && m_bursts > 0) check("href_gap", m_gap, HB);
                m_run++;
                check("byte_expected", {31'd0, exp_q.size() > 0}, 1);
                if (exp_q.size() > 0) check("pixel_byte", cam_data, exp_q.pop_front());
            end else begin
                check("data_zero_when_idle", cam_data, 8'h00);
                if (m_prev_href) begin
                    check("href_burst_len", m_run, 2 * HA);
                    m_bursts++;
                    m_run = 0;
                    m_gap = 0;
                end
                m_gap++;
            end

            if (!m_prev_vsync && cam_vsync) begin
                m_fc++;
                check("frame_count_at_rise", frame_count, m_fc % 65536);
                check("vsync_low_cycles", m_low, FRAME_LOW);
                check("bursts_per_frame", m_bursts, VA);
                check("frame_start_per_frame", m_fs, 1);
                check("queue_drained", exp_q.size(), 0);
            end
            m_prev_vsync = cam_vsync;
            m_prev_href  = cam_href;
        end
    end

    task automatic wait_vsync(input logic level, input int budget);
        int n = 0;
        while (cam_vsync !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_vsync", {31'd0, cam_vsync}, {31'd0, level});
    endtask

    task automatic wait_href_falls(input int count, input int budget);
        int   falls = 0;
        int   n = 0;
        logic prev = cam_href;
        while (falls < count && n < budget) begin
            @(negedge clk);
            n++;
            if (prev && !cam_href) falls++;
            prev = cam_href;
        end
        check("wait_href_falls", falls, count);
    endtask

    // Called on the negedge where the start condition was just applied.
    task automatic measure_start(input string name);
        int k = 0;
        while (cam_vsync !== 1'b0 && k < 4 * LB) begin
            @(negedge clk);
            k++;
        end
        check(name, k, VS * LB + 2);
    endtask

    // Called on the first sample with VSYNC high after a frame; queues the next frame.
    task automatic continue_frame(input int pat);
        int n = 1;
        frames_done++;
        @(negedge clk);
        pattern_sel = 2'(pat);
        push_frame(pat, frames_done);
        while (cam_vsync === 1'b1 && n < 4 * LB) begin
            n++;
            @(negedge clk);
        end
        check("vsync_high_cycles", n, VS * LB);
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n1;
        int pat;
        int lows;
        int pulses;

        nreset = 1'b0;
        enable = 1'b1;
        pattern_sel = 2'b00;

        repeat (6) begin
            @(negedge clk);
            check("rst_vsync", {31'd0, cam_vsync}, 1);
            check("rst_href", {31'd0, cam_href}, 0);
            check("rst_data", cam_data, 8'h00);
            check("rst_frame_start", {31'd0, frame_start}, 0);
            check("rst_frame_count", frame_count, 0);
        end

        // Frame 1: ramp, with an ignored switch to bars mid-ACTIVE.
        nreset = 1'b1;
        push_frame(0, frames_done);
        measure_start("start_latency_from_reset");
        wait_href_falls($urandom_range(1, VA - 2), FRAME_ALL);
        pattern_sel = 2'b01;
        wait_vsync(1'b1, 2 * FRAME_ALL);

        // Frame 2: checkerboard, again switched to bars mid-frame.
        continue_frame(2);
        wait_href_falls($urandom_range(1, VA - 2), FRAME_ALL);
        pattern_sel = 2'b01;
        wait_vsync(1'b1, 2 * FRAME_ALL);

        // Frame 3: flat field; enable drops in ACTIVE and returns during FRONT.
        continue_frame(3);
        n1 = $urandom_range(1, VA - 1);
        wait_href_falls(n1, FRAME_ALL);
        enable = 1'b0;
        wait_href_falls(VA - n1, FRAME_ALL);
        repeat (HB + $urandom_range(5, LB / 2)) @(negedge clk);
        check("still_in_front", {31'd0, cam_vsync}, 0);
        enable = 1'b1;
        wait_vsync(1'b1, 2 * FRAME_ALL);

        // Frame 4: random pattern; enable drops for good mid-ACTIVE.
        continue_frame($urandom_range(0, 3));
        wait_href_falls($urandom_range(1, VA - 2), FRAME_ALL);
        pattern_sel = 2'($urandom_range(0, 3));
        enable = 1'b0;
        wait_vsync(1'b1, 2 * FRAME_ALL);
        frames_done++;

        lows = 0;
        pulses = 0;
        repeat (3 * LB) begin
            @(negedge clk);
            if (!cam_vsync) lows++;
            if (frame_start) pulses++;
        end
        check("idle_vsync_low_cycles", lows, 0);
        check("idle_frame_start_pulses", pulses, 0);
        check("idle_frame_count", frame_count, 4);

        // Frame 5: re-enable from IDLE, then async reset mid active line.
        pat = $urandom_range(0, 3);
        pattern_sel = 2'(pat);
        push_frame(pat, frames_done);
        enable = 1'b1;
        measure_start("start_latency_reenable");
        wait_href_falls($urandom_range(1, VA - 2), FRAME_ALL);
        while (!cam_href && !cam_vsync) @(negedge clk);
        repeat ($urandom_range(3, 100)) @(negedge clk);
        @(posedge clk);
        #1;
        check("pre_reset_href", {31'd0, cam_href}, 1);
        #1 nreset = 1'b0;
        #1;
        check("async_rst_vsync", {31'd0, cam_vsync}, 1);
        check("async_rst_href", {31'd0, cam_href}, 0);
        check("async_rst_data", cam_data, 8'h00);
        check("async_rst_frame_count", frame_count, 0);
        check("async_rst_frame_start", {31'd0, frame_start}, 0);
        repeat (3) @(negedge clk);

        // Frame 6: full frame after reset release with enable held.
        frames_done = 0;
        nreset = 1'b1;
        pat = $urandom_range(0, 3);
        pattern_sel = 2'(pat);
        push_frame(pat, frames_done);
        measure_start("start_latency_after_async_reset");
        wait_href_falls($urandom_range(1, VA - 2), FRAME_ALL);
        pattern_sel = 2'($urandom_range(0, 3));
        wait_vsync(1'b1, 2 * FRAME_ALL);
        @(negedge clk);
        check("final_frame_count", frame_count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/camera_pattern_source.md
# camera_pattern_source

Synthetic camera transmitter that drives the same VSYNC/HREF/8-bit YUV422 byte interface the capture/threshold path consumes. It runs on the camera pixel clock and generates complete frames of a selectable test pattern. It replaces the physical sensor for bring-up, threshold tuning and simulation of the SPRAM bitmask path. Output polarity: VSYNC HIGH = idle/sync, LOW = active frame; HREF HIGH = valid byte.

## Interface

Parameters:
- H_ACTIVE, 320, pixels per active line; each line carries 2*H_ACTIVE bytes.
- H_BLANK, 144, HREF-low bytes after each line's active bytes; must be >= 1.
- V_ACTIVE, 240, active lines per frame.
- VSYNC_LINES, 3, lines with VSYNC high between frames; must be >= 1.
- V_BACK, 17, VSYNC-low, HREF-low lines before the first active line; must be >= 1.
- V_FRONT, 10, VSYNC-low, HREF-low lines after the last active line; must be >= 1.

Ports:
- cam_pclk  in  1  pixel clock; sole clock.
- nreset  in  1  asynchronous, active-low reset.
- enable  in  1  run request; sampled only at frame boundaries.
- pattern_sel  in  2  pattern select; latched at frame start.
- cam_vsync  out  1  frame sync (HIGH idle/sync, LOW active frame); registered.
- cam_href  out  1  byte-valid; registered.
- cam_data  out  8  YUV422 byte stream; registered.
- frame_start  out  1  one-cycle pulse, coincident with the cycle cam_vsync first reads LOW.
- frame_count  out  16  completed frames; increments when cam_vsync rises at frame end; wraps 0xFFFF -> 0.

## Operation

- LINE_BYTES = 2*H_ACTIVE + H_BLANK. byte_cnt counts 0..LINE_BYTES-1, wraps, and advances line_cnt. line_cnt clears on each state change.
- FSM states:
  - IDLE: when enable = 1 -> VSYNC, counters cleared.
  - VSYNC: VSYNC_LINES lines -> BACK. On entry to BACK, latch pattern_sel and emit frame_start.
  - BACK: V_BACK lines -> ACTIVE.
  - ACTIVE: V_ACTIVE lines -> FRONT.
  - FRONT: V_FRONT lines -> VSYNC if enable = 1, else IDLE.
- Output decode (registered, computed from current state and counters):
  - cam_vsync = 1 in IDLE and VSYNC, else 0.
  - cam_href = 1 only in ACTIVE with byte_cnt < 2*H_ACTIVE.
  - cam_data = 0x00 whenever href is low.
- Active byte order per line is Y0 U Y1 V Y2 U ...:
  - Even byte_cnt carries Y for pixel x = byte_cnt>>1.
  - Odd bytes carry 0x80 (neutral chroma).
  - y is the ACTIVE line index, 0..V_ACTIVE-1.
- Y by latched pattern:
  - 00 horizontal ramp: x[7:0]. Wraps at x = 256.
  - 01 vertical bars: x[5] ? 0xFF : 0x00.
  - 10 checkerboard: (x[4]^y[4]) ? 0xFF : 0x00.
  - 11 flat field: frame_count[7:0] as latched at frame start.
- Boundary conditions:
  - A pattern_sel change mid-frame is ignored until the next BACK entry.
  - enable deasserting mid-frame: the current frame completes through FRONT, frame_count increments, then IDLE. No truncated frames are ever emitted.
  - enable reasserting during FRONT of the last frame: the FSM continues directly to VSYNC.
  - Async reset mid-frame: outputs return immediately to reset values. The downstream capture block sees a VSYNC rise and treats it as frame end.

## Timing

- Reset values: cam_vsync = 1, cam_href = 0, cam_data = 0x00, frame_start = 0, frame_count = 0, FSM in IDLE, counters 0.
- Output latency: outputs lag the state/counters by exactly one cam_pclk.
- Enable start: enable is sampled high at edge E0. cam_vsync falls after edge E0 + VSYNC_LINES*LINE_BYTES + 1, and frame_start is high in that same cycle.
- Per frame: cam_vsync is low for (V_BACK+V_ACTIVE+V_FRONT)*LINE_BYTES cycles.
  - Defaults: 267*784 = 209328 cycles low; frame period 270*784 = 211680 cycles.
- Per active line: HREF is high for 2*H_ACTIVE consecutive cycles (640 by default), then low for H_BLANK cycles.
- frame_count updates in the same cycle cam_vsync rises.

## Test plan

- Reset: hold nreset = 0 with enable = 1 -> cam_vsync = 1, cam_href = 0, cam_data = 0x00, frame_count = 0; no toggling.
- Default frame geometry, enable = 1:
  - 240 HREF bursts of exactly 640 cycles, with 144 low cycles between bursts.
  - cam_vsync low for 209328 cycles.
  - frame_count goes 0 -> 1 at the VSYNC rise.
  - One frame_start pulse per frame.
- Ramp, pattern_sel = 00: first active line bytes read 00,80,01,80,02,80...; byte 510 = 0xFF; byte 512 (x = 256) = 0x00.
- Checkerboard and latching:
  - pattern_sel = 10: line 0 pixel 16 = 0xFF; line 16 pixel 0 = 0xFF; line 16 pixel 16 = 0x00.
  - Switching to 01 mid-ACTIVE changes nothing until the next frame.
- Disable mid-frame, with H_ACTIVE=4, H_BLANK=2, V_ACTIVE=3, all porches = 1:
  - Dropping enable in ACTIVE still yields 3 full HREF bursts of 8 cycles; frame_count increments once; cam_vsync then stays high.
  - Re-enabling starts a new frame after 1 VSYNC line (10 cycles).
- Async reset mid-active-line: cam_href and cam_data drop and cam_vsync rises within the reset-asserted interval, with no clock edge; frame_count = 0. After release with enable = 1, a full frame follows.
